// File: rtl/sb_pkg.sv
// -----------------------------------------------------------------------------
// sb_pkg
// Shared types, constants and helpers for the register scoreboard.
//   sb_entry_t : per-register pair of in-flight counters (all writers, loads)
//   sb_hit_t   : operand lookup result {stall, fwd}
//   sb_hit()   : classifies one entry as load-use stall or forwardable
// -----------------------------------------------------------------------------
package sb_pkg;

   localparam int NREG      = 32;        // architectural GRs, r0 untracked
   localparam int CNT_W     = 2;         // per-register counter width
   localparam int TOT_W     = 6;         // nominal total-counter width
   localparam int SB_AW     = 5;         // GR address width
   // One extra bit so 31 x 3 writers can never wrap the total counter.
   localparam int SB_TOT_IW = TOT_W + 1;

   typedef logic [CNT_W-1:0] sb_cnt_t;

   localparam sb_cnt_t SB_CNT_MAX  = {CNT_W{1'b1}};
   localparam sb_cnt_t SB_CNT_ZERO = {CNT_W{1'b0}};
   localparam sb_cnt_t SB_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   localparam logic [SB_TOT_IW-1:0] SB_TOT_ZERO = {SB_TOT_IW{1'b0}};
   localparam logic [SB_TOT_IW-1:0] SB_TOT_ONE  = {{(SB_TOT_IW-1){1'b0}}, 1'b1};

   typedef struct packed {
      sb_cnt_t cnt;      // in-flight writers of this register
      sb_cnt_t ld_cnt;   // in-flight loads whose data has not returned yet
   } sb_entry_t;

   typedef struct packed {
      logic stall;
      logic fwd;
   } sb_hit_t;

   // A pending writer is forwardable only once every pending load has returned.
   function automatic sb_hit_t sb_hit(input sb_entry_t entry);
      sb_hit_t hit;
      hit.stall = (entry.cnt != SB_CNT_ZERO) && (entry.ld_cnt != SB_CNT_ZERO);
      hit.fwd   = (entry.cnt != SB_CNT_ZERO) && (entry.ld_cnt == SB_CNT_ZERO);
      return hit;
   endfunction

endpackage

// File: rtl/sb_entry.sv
// -----------------------------------------------------------------------------
// sb_entry
// Counter pair for one architectural register.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clr        : discard all in-flight writers (pipeline flush)
//   inc        : a writer to this register issues
//   dec        : a writer to this register retires
//   ld_inc     : the issuing writer is a load (only meaningful with inc)
//   ld_dec     : load data for this register returned in MEM
//   entry      : registered counter pair
//   err        : single-cycle pulse, an event was rejected (counter full/empty)
// -----------------------------------------------------------------------------
module sb_entry
   import sb_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      clr,
   input  logic      inc,
   input  logic      dec,
   input  logic      ld_inc,
   input  logic      ld_dec,
   output sb_entry_t entry,
   output logic      err
);

   sb_entry_t entry_r;
   sb_entry_t entry_nxt_s;
   logic      inc_take_s;
   logic      dec_take_s;
   logic      ld_inc_take_s;
   logic      ld_dec_take_s;

   // Accept each event only when its counter has room; rejected ones leave the
   // counter untouched. A rejected issue also drops its load half.
   always_comb begin
      inc_take_s    = inc && (entry_r.cnt != SB_CNT_MAX);
      dec_take_s    = dec && (entry_r.cnt != SB_CNT_ZERO);
      ld_inc_take_s = ld_inc && inc_take_s && (entry_r.ld_cnt != SB_CNT_MAX);
      ld_dec_take_s = ld_dec && (entry_r.ld_cnt != SB_CNT_ZERO);
      // A flush overrides every event, so nothing it discards is an error.
      err = !clr && ((inc && !inc_take_s) ||
                     (dec && !dec_take_s) ||
                     (ld_inc && inc_take_s && !ld_inc_take_s) ||
                     (ld_dec && !ld_dec_take_s));
   end

   // Net-sum update: simultaneous +1 and -1 cancel out.
   always_comb begin
      entry_nxt_s = entry_r;
      case ({inc_take_s, dec_take_s})
         2'b10:   entry_nxt_s.cnt = entry_r.cnt + SB_CNT_ONE;
         2'b01:   entry_nxt_s.cnt = entry_r.cnt - SB_CNT_ONE;
         default: entry_nxt_s.cnt = entry_r.cnt;
      endcase
      case ({ld_inc_take_s, ld_dec_take_s})
         2'b10:   entry_nxt_s.ld_cnt = entry_r.ld_cnt + SB_CNT_ONE;
         2'b01:   entry_nxt_s.ld_cnt = entry_r.ld_cnt - SB_CNT_ONE;
         default: entry_nxt_s.ld_cnt = entry_r.ld_cnt;
      endcase
   end

   // Counter state; flush clears it like reset but synchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         entry_r <= {SB_CNT_ZERO, SB_CNT_ZERO};
      end else if (clr) begin
         entry_r <= {SB_CNT_ZERO, SB_CNT_ZERO};
      end else begin
         entry_r <= entry_nxt_s;
      end
   end

   assign entry = entry_r;

endmodule

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// Per-register in-flight write tracker feeding the ID hazard logic.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   id_issue          : ID->EXE handshake fires this cycle
//   id_gr_we          : issuing instruction writes a GR
//   id_load_op        : issuing instruction is a load
//   id_dest           : destination of the issuing instruction
//   id_raddr1/2       : ID operand read addresses
//   ms_load_done      : load data valid in MEM, ms_dest is its destination
//   ws_retire         : WB writes the regfile, ws_dest is its destination
//   flush             : discard every in-flight instruction
//   issue_ready       : ID may issue a writer to id_dest
//   stall1/2          : operand has a pending load result (load-use)
//   fwd_ok1/2         : operand has a pending writer whose value can be forwarded
//   busy_vec          : bit i set while GR i has any in-flight writer
//   drained           : nothing in flight
//   sb_err            : sticky protocol-error flag
// All outputs derive from registered state; an issue becomes visible next cycle.
// -----------------------------------------------------------------------------
module reg_scoreboard
   import sb_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             id_issue,
   input  logic             id_gr_we,
   input  logic             id_load_op,
   input  logic [SB_AW-1:0] id_dest,
   input  logic [SB_AW-1:0] id_raddr1,
   input  logic [SB_AW-1:0] id_raddr2,
   input  logic             ms_load_done,
   input  logic [SB_AW-1:0] ms_dest,
   input  logic             ws_retire,
   input  logic [SB_AW-1:0] ws_dest,
   input  logic             flush,
   output logic             issue_ready,
   output logic             stall1,
   output logic             stall2,
   output logic             fwd_ok1,
   output logic             fwd_ok2,
   output logic [NREG-1:0]  busy_vec,
   output logic             drained,
   output logic             sb_err
);

   localparam logic [SB_AW-1:0] R0 = {SB_AW{1'b0}};

   sb_entry_t            ent_s [NREG];
   logic [NREG-1:0]      ent_err_s;
   logic [SB_TOT_IW-1:0] tot_r;
   logic                 err_r;
   logic                 issue_evt_s;
   logic                 load_evt_s;
   logic                 retire_evt_s;
   logic                 issue_take_s;
   logic                 retire_take_s;
   sb_hit_t              hit1_s;
   sb_hit_t              hit2_s;

   // r0 is hard-wired to zero and never tracked.
   assign ent_s[0]     = {SB_CNT_ZERO, SB_CNT_ZERO};
   assign ent_err_s[0] = 1'b0;

   assign issue_evt_s  = id_issue && id_gr_we && (id_dest != R0);
   assign load_evt_s   = ms_load_done && (ms_dest != R0);
   assign retire_evt_s = ws_retire && (ws_dest != R0);

   generate
      for (genvar i = 1; i < NREG; i++) begin : g_ent
         localparam logic [SB_AW-1:0] IDX = SB_AW'(i);
         sb_entry u_entry (
            .clk    (clk),
            .reset  (reset),
            .clr    (flush),
            .inc    (issue_evt_s && (id_dest == IDX)),
            .dec    (retire_evt_s && (ws_dest == IDX)),
            .ld_inc (issue_evt_s && id_load_op && (id_dest == IDX)),
            .ld_dec (load_evt_s && (ms_dest == IDX)),
            .entry  (ent_s[i]),
            .err    (ent_err_s[i])
         );
      end
   endgenerate

   // Events that the addressed entry actually accepts drive the total count.
   always_comb begin
      issue_take_s  = issue_evt_s && (ent_s[id_dest].cnt != SB_CNT_MAX);
      retire_take_s = retire_evt_s && (ent_s[ws_dest].cnt != SB_CNT_ZERO);
   end

   // Total in-flight writers; wide enough that it cannot wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tot_r <= SB_TOT_ZERO;
      end else if (flush) begin
         tot_r <= SB_TOT_ZERO;
      end else begin
         case ({issue_take_s, retire_take_s})
            2'b10:   tot_r <= tot_r + SB_TOT_ONE;
            2'b01:   tot_r <= tot_r - SB_TOT_ONE;
            default: tot_r <= tot_r;
         endcase
      end
   end

   // Sticky error: only reset clears it, flush does not.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_r <= 1'b0;
      end else begin
         err_r <= err_r | (|ent_err_s);
      end
   end

   // Operand lookups and status outputs from registered state.
   always_comb begin
      hit1_s      = sb_hit(ent_s[id_raddr1]);
      hit2_s      = sb_hit(ent_s[id_raddr2]);
      stall1      = (id_raddr1 != R0) && hit1_s.stall;
      fwd_ok1     = (id_raddr1 != R0) && hit1_s.fwd;
      stall2      = (id_raddr2 != R0) && hit2_s.stall;
      fwd_ok2     = (id_raddr2 != R0) && hit2_s.fwd;
      issue_ready = !((ent_s[id_dest].cnt == SB_CNT_MAX) && (id_dest != R0)) && !flush;
      drained     = (tot_r == SB_TOT_ZERO);
      sb_err      = err_r;
      busy_vec    = {NREG{1'b0}};
      for (int i = 0; i < NREG; i++) begin
         busy_vec[i] = (ent_s[i].cnt != SB_CNT_ZERO);
      end
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_issue, id_gr_we, id_load_op;
   logic [4:0]  id_dest, id_raddr1, id_raddr2;
   logic        ms_load_done;
   logic [4:0]  ms_dest;
   logic        ws_retire;
   logic [4:0]  ws_dest;
   logic        flush;
   logic        issue_ready, stall1, stall2, fwd_ok1, fwd_ok2;
   logic [31:0] busy_vec;
   logic        drained, sb_err;

   int checks = 0;
   int errors = 0;

   // Reference model: plain integer counts per register plus a sticky error.
   int m_cnt [32];
   int m_ld  [32];
   bit m_err;

   reg_scoreboard dut (
      .clk          (clk),
      .reset        (reset),
      .id_issue     (id_issue),
      .id_gr_we     (id_gr_we),
      .id_load_op   (id_load_op),
      .id_dest      (id_dest),
      .id_raddr1    (id_raddr1),
      .id_raddr2    (id_raddr2),
      .ms_load_done (ms_load_done),
      .ms_dest      (ms_dest),
      .ws_retire    (ws_retire),
      .ws_dest      (ws_dest),
      .flush        (flush),
      .issue_ready  (issue_ready),
      .stall1       (stall1),
      .stall2       (stall2),
      .fwd_ok1      (fwd_ok1),
      .fwd_ok2      (fwd_ok2),
      .busy_vec     (busy_vec),
      .drained      (drained),
      .sb_err       (sb_err)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin
         m_cnt[i] = 0;
         m_ld[i]  = 0;
      end
   endtask

   task automatic idle_inputs();
      id_issue     = 1'b0;
      id_gr_we     = 1'b0;
      id_load_op   = 1'b0;
      ms_load_done = 1'b0;
      ws_retire    = 1'b0;
      flush        = 1'b0;
   endtask

   // Apply this cycle's events to the model using start-of-cycle counts.
   task automatic model_update();
      int oc [32];
      int ol [32];
      oc = m_cnt;
      ol = m_ld;
      if (flush) begin
         model_clear();
      end else begin
         if (id_issue && id_gr_we && id_dest != 5'd0) begin
            if (oc[id_dest] == 3) m_err = 1'b1;
            else begin
               m_cnt[id_dest]++;
               if (id_load_op) begin
                  if (ol[id_dest] == 3) m_err = 1'b1;
                  else m_ld[id_dest]++;
               end
            end
         end
         if (ms_load_done && ms_dest != 5'd0) begin
            if (ol[ms_dest] == 0) m_err = 1'b1;
            else m_ld[ms_dest]--;
         end
         if (ws_retire && ws_dest != 5'd0) begin
            if (oc[ws_dest] == 0) m_err = 1'b1;
            else m_cnt[ws_dest]--;
         end
      end
   endtask

   task automatic check_model();
      int          tot;
      logic [31:0] eb;
      tot = 0;
      eb  = 32'd0;
      for (int i = 1; i < 32; i++) begin
         eb[i] = (m_cnt[i] > 0);
         tot  += m_cnt[i];
      end
      chk_eq("busy_vec", busy_vec, eb);
      chk_eq("drained", drained, tot == 0);
      chk_eq("stall1", stall1, id_raddr1 != 5'd0 && m_cnt[id_raddr1] > 0 && m_ld[id_raddr1] > 0);
      chk_eq("fwd_ok1", fwd_ok1, id_raddr1 != 5'd0 && m_cnt[id_raddr1] > 0 && m_ld[id_raddr1] == 0);
      chk_eq("stall2", stall2, id_raddr2 != 5'd0 && m_cnt[id_raddr2] > 0 && m_ld[id_raddr2] > 0);
      chk_eq("fwd_ok2", fwd_ok2, id_raddr2 != 5'd0 && m_cnt[id_raddr2] > 0 && m_ld[id_raddr2] == 0);
      chk_eq("issue_ready", issue_ready, !(id_dest != 5'd0 && m_cnt[id_dest] == 3) && !flush);
      chk_eq("sb_err", sb_err, m_err);
   endtask

   // Called at posedge+1 with inputs set; checks at posedge+3.
   task automatic sample();
      #2;
      check_model();
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
      idle_inputs();
   endtask

   task automatic cycle();
      sample();
      tick();
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      model_clear();
      m_err = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic set_issue(input logic [4:0] d, input logic ld);
      id_issue   = 1'b1;
      id_gr_we   = 1'b1;
      id_load_op = ld;
      id_dest    = d;
   endtask

   task automatic retire(input logic [4:0] d);
      ws_retire = 1'b1;
      ws_dest   = d;
   endtask

   task automatic random_cycle();
      int d, found;
      if ($urandom_range(0, 39) == 0) begin
         flush = 1'b1;
         if (m_cnt[1] > m_ld[1]) retire(5'd1);
      end else begin
         if ($urandom_range(0, 1) != 0) begin
            d          = $urandom_range(0, 9);
            id_dest    = 5'(d);
            id_gr_we   = ($urandom_range(0, 3) != 0);
            id_load_op = ($urandom_range(0, 2) == 0);
            id_issue   = (d == 0 || m_cnt[d] < 3);
         end else begin
            id_dest = 5'($urandom_range(0, 9));
         end
         found = -1;
         d     = $urandom_range(0, 31);
         for (int k = 0; k < 32; k++) begin
            if (found < 0 && ((d + k) % 32) != 0 && m_ld[(d + k) % 32] > 0) found = (d + k) % 32;
         end
         if (found > 0 && $urandom_range(0, 2) != 0) begin
            ms_load_done = 1'b1;
            ms_dest      = 5'(found);
         end else if ($urandom_range(0, 7) == 0) begin
            ms_load_done = 1'b1;
            ms_dest      = 5'd0;
         end
         found = -1;
         d     = $urandom_range(0, 31);
         for (int k = 0; k < 32; k++) begin
            if (found < 0 && ((d + k) % 32) != 0 && m_cnt[(d + k) % 32] > m_ld[(d + k) % 32]) found = (d + k) % 32;
         end
         if (found > 0 && $urandom_range(0, 2) != 0) retire(5'(found));
         else if ($urandom_range(0, 7) == 0) retire(5'd0);
      end
      id_raddr1 = 5'($urandom_range(0, 9));
      id_raddr2 = 5'($urandom_range(0, 9));
      cycle();
   endtask

   initial begin
      idle_inputs();
      id_dest   = 5'd0;
      id_raddr1 = 5'd0;
      id_raddr2 = 5'd0;
      ms_dest   = 5'd0;
      ws_dest   = 5'd0;
      m_err     = 1'b0;
      model_clear();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state
      id_raddr1 = 5'd5;
      sample();
      chk_eq("rst_drained", drained, 1'b1);
      chk_eq("rst_busy", busy_vec, 32'd0);
      chk_eq("rst_ready", issue_ready, 1'b1);
      tick();

      // ALU producer r5
      set_issue(5'd5, 1'b0);
      cycle();
      sample();
      chk_eq("alu_fwd1", fwd_ok1, 1'b1);
      chk_eq("alu_stall1", stall1, 1'b0);
      chk_eq("alu_busy5", busy_vec[5], 1'b1);
      chk_eq("alu_drained", drained, 1'b0);
      tick();
      cycle();
      cycle();
      retire(5'd5);
      cycle();
      sample();
      chk_eq("alu_busy_clr", busy_vec, 32'd0);
      chk_eq("alu_drained2", drained, 1'b1);
      tick();

      // Load-use r7
      set_issue(5'd7, 1'b1);
      cycle();
      id_raddr2 = 5'd7;
      sample();
      chk_eq("ld_stall2_a", stall2, 1'b1);
      tick();
      ms_load_done = 1'b1;
      ms_dest      = 5'd7;
      sample();
      chk_eq("ld_stall2_b", stall2, 1'b1);
      tick();
      sample();
      chk_eq("ld_stall2_c", stall2, 1'b0);
      chk_eq("ld_fwd2", fwd_ok2, 1'b1);
      tick();
      retire(5'd7);
      cycle();

      // Saturation r3
      for (int i = 0; i < 3; i++) begin
         set_issue(5'd3, 1'b0);
         cycle();
      end
      id_dest = 5'd3;
      sample();
      chk_eq("sat_ready3", issue_ready, 1'b0);
      id_dest = 5'd4;
      sample();
      chk_eq("sat_ready4", issue_ready, 1'b1);
      tick();
      retire(5'd3);
      id_dest = 5'd3;
      cycle();
      sample();
      chk_eq("sat_ready3_back", issue_ready, 1'b1);
      tick();
      retire(5'd3);
      cycle();
      retire(5'd3);
      cycle();

      // Simultaneous issue + load return + retire on r9
      set_issue(5'd9, 1'b1);
      cycle();
      set_issue(5'd9, 1'b0);
      ms_load_done = 1'b1;
      ms_dest      = 5'd9;
      retire(5'd9);
      cycle();
      id_raddr1 = 5'd9;
      sample();
      chk_eq("sim_fwd1", fwd_ok1, 1'b1);
      chk_eq("sim_stall1", stall1, 1'b0);
      chk_eq("sim_busy9", busy_vec[9], 1'b1);
      chk_eq("sim_err", sb_err, 1'b0);
      tick();
      retire(5'd9);
      cycle();

      // Flush with 4 in flight and a same-cycle retire
      set_issue(5'd1, 1'b0);
      cycle();
      set_issue(5'd2, 1'b0);
      cycle();
      set_issue(5'd10, 1'b1);
      cycle();
      set_issue(5'd11, 1'b0);
      cycle();
      flush = 1'b1;
      retire(5'd1);
      cycle();
      sample();
      chk_eq("fl_busy", busy_vec, 32'd0);
      chk_eq("fl_drained", drained, 1'b1);
      chk_eq("fl_err", sb_err, 1'b0);
      tick();

      // Randomized traffic
      for (int n = 0; n < 2000; n++) random_cycle();

      // Load return with nothing pending
      do_reset();
      ms_load_done = 1'b1;
      ms_dest      = 5'd13;
      cycle();
      sample();
      chk_eq("err_ldret", sb_err, 1'b1);
      tick();

      // Issue to a full register: rejected, counter stays at 3
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_issue(5'd3, 1'b0);
         cycle();
      end
      sample();
      chk_eq("err_issue", sb_err, 1'b1);
      tick();
      for (int i = 0; i < 3; i++) begin
         retire(5'd3);
         cycle();
      end
      sample();
      chk_eq("err_issue_sat", busy_vec[3], 1'b0);
      tick();

      // Retire with nothing pending, then asynchronous reset mid-cycle
      do_reset();
      set_issue(5'd20, 1'b0);
      cycle();
      retire(5'd12);
      cycle();
      cycle();
      cycle();
      id_raddr1 = 5'd20;
      id_dest   = 5'd20;
      sample();
      chk_eq("err_retire_hold", sb_err, 1'b1);
      reset = 1'b1;
      #1;
      chk_eq("arst_err", sb_err, 1'b0);
      chk_eq("arst_busy", busy_vec, 32'd0);
      chk_eq("arst_drained", drained, 1'b1);
      chk_eq("arst_fwd1", fwd_ok1, 1'b0);
      chk_eq("arst_ready", issue_ready, 1'b1);
      #2;
      reset = 1'b0;
      model_clear();
      m_err = 1'b0;
      @(posedge clk);
      #1;
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Per-register in-flight write tracker for the 5-stage LoongArch pipeline; it replaces the stage-by-stage destination compares in the ID hazard logic.
- It records each GR-writing instruction as it leaves ID, marks load results forwardable when MEM returns the data, and releases the entry when WB writes the regfile.
- Outputs per-operand stall and forward-permit signals to ID, an issue throttle, and a drain indication used by ertn/idle sequencing.

Parameters:
- NREG, 32, number of architectural GRs; r0 is never tracked.
- CNT_W, 2, width of per-register in-flight counters; max in-flight writers per register is 2^CNT_W-1 = 3.
- TOT_W, 6, width of the total in-flight counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- id_issue  in  1  ID→EXE handshake fires this cycle.
- id_gr_we  in  1  issuing instruction writes a GR.
- id_load_op  in  1  issuing instruction is a load.
- id_dest  in  5  destination of the issuing instruction.
- id_raddr1  in  5  ID read address, port 1.
- id_raddr2  in  5  ID read address, port 2.
- ms_load_done  in  1  load data is valid in MEM this cycle.
- ms_dest  in  5  destination of that load.
- ws_retire  in  1  WB writes the regfile this cycle (ws_valid && gr_we).
- ws_dest  in  5  WB destination.
- flush  in  1  exception/ertn flush; discards all in-flight instructions.
- issue_ready  out  1  ID may issue a writer to id_dest.
- stall1  out  1  operand 1 has an unforwardable pending writer.
- stall2  out  1  operand 2 has an unforwardable pending writer.
- fwd_ok1  out  1  operand 1 has a pending writer whose value is forwardable.
- fwd_ok2  out  1  operand 2 has a pending writer whose value is forwardable.
- busy_vec  out  32  bit i = GR i has any in-flight writer.
- drained  out  1  no instructions in flight.
- sb_err  out  1  sticky protocol-error flag.

Behaviour:
- State per register i=1..31: cnt[i] counts in-flight writers; ld_cnt[i] counts in-flight loads not yet returned. Invariant: ld_cnt ≤ cnt. Also kept: total counter tot, and the sticky err bit.
- Reset (asynchronous): all cnt, ld_cnt and tot clear; err clears. Resulting outputs: issue_ready=1, stall*=0, fwd_ok*=0, busy_vec=0, drained=1, sb_err=0.
- Issue: when id_issue && id_gr_we && id_dest!=0, cnt[id_dest]+1 applies at the next edge. If id_load_op is also set, ld_cnt[id_dest]+1 applies at the same edge.
- Load return: when ms_load_done && ms_dest!=0, ld_cnt[ms_dest]-1.
- Retire: when ws_retire && ws_dest!=0, cnt[ws_dest]-1.
- Simultaneous events on the same register: the net sum is applied (+1-1 = no change). All three event types can hit one register in the same cycle.
- tot is updated by the net count of issues and retires. drained = (tot==0).
- Outputs are combinational from registered state only. An instruction issuing this cycle is visible to ID reads from the next cycle.
- For each operand k with raddr r:
  - r==0: stallk=0 and fwd_okk=0.
  - Otherwise stallk = cnt[r]!=0 && ld_cnt[r]!=0 (load-use).
  - Otherwise fwd_okk = cnt[r]!=0 && ld_cnt[r]==0.
- issue_ready = !(cnt[id_dest]==3 && id_dest!=0) && !flush.
- flush: all cnt, ld_cnt and tot clear at the next edge. A flush overrides any issue, load-return or retire in the same cycle. The WB instruction in that cycle has already committed, so its slot is discarded with the rest.
- Errors: any of the following sets err, and it stays set until reset. In each case the offending counter is left unchanged (saturates, no wrap).
  - Retire with cnt==0.
  - Load return with ld_cnt==0.
  - Issue while issue_ready=0.
- Wrap-around: tot never exceeds 31×3, so the 6-bit TOT_W setting overflows at 64. Implementation: size tot ≥ 7 bits internally, or bound it to 63 and flag err on overflow.

Decomposition:
- Package sb_pkg holds:
  - typedef sb_entry_t {cnt[CNT_W-1:0], ld_cnt[CNT_W-1:0]};
  - localparams SB_CNT_MAX and NREG;
  - the function sb_hit(entry) returning {stall, fwd}.
- One sub-module, sb_entry: a single register's counter pair with inc/dec/ld_inc/ld_dec/clr inputs and an err pulse output. It is instantiated 31 times with a generate loop; r0 is tied off.

Test Plan:
- ALU producer: issue add.w r5 at cycle 0; at cycle 1 set raddr1=5 → fwd_ok1=1, stall1=0, busy_vec[5]=1, drained=0. Retire r5 at cycle 4 → busy_vec=0 and drained=1 at cycle 5.
- Load-use: issue ld.w r7; raddr2=7 → stall2=1 until ms_load_done(ms_dest=7). The cycle after that, stall2=0 and fwd_ok2=1.
- Saturation: issue three writers to r3 with no retire → issue_ready=0 for id_dest=3 and =1 for id_dest=4. One retire of r3 → issue_ready returns to 1.
- Simultaneous: issue r9, ms_load_done r9 and retire r9 all in one cycle, with prior cnt=1 and ld_cnt=1 → the next cycle holds cnt=1, ld_cnt=0, and sb_err=0.
- Flush: 4 instructions in flight, flush asserted together with ws_retire → next cycle busy_vec=0, drained=1, sb_err=0.
- Error and async reset: retire r12 with cnt=0 → sb_err=1 and it holds. Asserting reset mid-cycle → all outputs reach their reset values immediately, without waiting for a clock edge.
